paddle_ctrl_multi: RTL

//  Multi-channel paddle position controller for the Pong game datapath.

---
 rtl/paddle_ctrl_multi.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/paddle_ctrl_multi.sv
// Multi-channel paddle controller: per-pad left/right FSM with per-frame speed ramp and exact edge clamping.
// Optional macro PADDLE_AUTO_EN adds auto_en/target_x so a pad can track a target x instead of buttons.
module paddle_ctrl_multi #(
  parameter int NUM_PADS     = 2,
  parameter int SCREEN_WIDTH = 430,
  parameter int PAD_WIDTH    = 40,
  parameter int MIN_SPEED    = 1,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_TICKS  = 8,
  localparam int XW          = $clog2(SCREEN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_PADS-1:0]    left,
  input  logic [NUM_PADS-1:0]    right,
`ifdef PADDLE_AUTO_EN
  input  logic [NUM_PADS-1:0]    auto_en,
  input  logic [NUM_PADS*XW-1:0] target_x,
`endif
  output logic [NUM_PADS*XW-1:0] pad_xpos,
  output logic [NUM_PADS-1:0]    at_left,
  output logic [NUM_PADS-1:0]    at_right,
  output logic [NUM_PADS-1:0]    moving
);

  localparam int XMAX = SCREEN_WIDTH - PAD_WIDTH;
  localparam int SW   = $clog2(MAX_SPEED + 1);
  localparam int CW   = $clog2(ACCEL_TICKS + 1);

  localparam logic [XW-1:0] XINIT   = XW'(SCREEN_WIDTH / 2 - PAD_WIDTH / 2);
  localparam logic [XW:0]   XMAX_W  = (XW + 1)'(XMAX);
  localparam logic [SW-1:0] SPD_MIN = SW'(MIN_SPEED);
  localparam logic [SW-1:0] SPD_MAX = SW'(MAX_SPEED);
  localparam logic [SW-1:0] SPD_ONE = SW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(ACCEL_TICKS);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    state_t        state_q, state_d;
    logic [XW-1:0] xpos_q, xpos_d;
    logic [SW-1:0] speed_q, speed_d, base_speed, step;
    logic [CW-1:0] cnt_q, cnt_d, base_cnt;
    logic          moving_q, moving_d;
    logic          req_l, req_r, ramp;
    logic [XW:0]   x_ext, step_ext, x_sum;

`ifdef PADDLE_AUTO_EN
    localparam logic [XW+1:0] HALF_PAD = (XW + 2)'(PAD_WIDTH / 2);
    localparam logic [XW+1:0] ONE_W    = (XW + 2)'(1);
    logic [XW+1:0] centre, tgt;

    // Dead band of +/-1 px around the target stops the pad hunting back and forth.
    always_comb begin
      centre = (XW + 2)'(xpos_q) + HALF_PAD;
      tgt    = (XW + 2)'(target_x[i*XW +: XW]);
      if (auto_en[i]) begin
        req_r = (centre + ONE_W) < tgt;
        req_l = centre > (tgt + ONE_W);
      end else begin
        req_l = left[i] & ~right[i];
        req_r = right[i] & ~left[i];
      end
    end
`else
    assign req_l = left[i] & ~right[i];
    assign req_r = right[i] & ~left[i];
`endif

    always_comb begin
      state_d    = state_q;
      speed_d    = speed_q;
      cnt_d      = cnt_q;
      step       = '0;
      ramp       = 1'b0;
      base_speed = speed_q;
      base_cnt   = cnt_q;

      if (!(req_l || req_r)) begin
        state_d = IDLE;
        speed_d = SPD_MIN;
        cnt_d   = '0;
      end else if (state_q == IDLE) begin
        // The first tick of a press already counts toward the ramp.
        state_d    = req_r ? MOVE_R : MOVE_L;
        step       = SPD_MIN;
        ramp       = 1'b1;
        base_speed = SPD_MIN;
        base_cnt   = '0;
      end else if ((state_q == MOVE_R) == req_r) begin
        step = speed_q;
        ramp = 1'b1;
      end else begin
        state_d = req_r ? MOVE_R : MOVE_L;
        step    = SPD_MIN;
        speed_d = SPD_MIN;
        cnt_d   = '0;
      end

      if (ramp) begin
        if (base_cnt + CNT_ONE == CNT_TOP) begin
          cnt_d   = '0;
          speed_d = (base_speed < SPD_MAX) ? base_speed + SPD_ONE : base_speed;
        end else begin
          cnt_d   = base_cnt + CNT_ONE;
          speed_d = base_speed;
        end
      end

      // One extra bit of headroom so neither direction can wrap.
      x_ext    = {1'b0, xpos_q};
      step_ext = (XW + 1)'(step);
      x_sum    = x_ext + step_ext;
      xpos_d   = xpos_q;
      if (req_l) begin
        xpos_d = (x_ext < step_ext) ? '0 : XW'(x_ext - step_ext);
      end else if (req_r) begin
        xpos_d = (x_sum > XMAX_W) ? XMAX_W[XW-1:0] : x_sum[XW-1:0];
      end
      moving_d = (xpos_d != xpos_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        xpos_q   <= XINIT;
        speed_q  <= SPD_MIN;
        cnt_q    <= '0;
        moving_q <= 1'b0;
      end else if (frame_tick) begin
        state_q  <= state_d;
        xpos_q   <= xpos_d;
        speed_q  <= speed_d;
        cnt_q    <= cnt_d;
        moving_q <= moving_d;
      end
    end

    assign pad_xpos[i*XW +: XW] = xpos_q;
    assign at_left[i]           = (xpos_q == '0);
    assign at_right[i]          = ({1'b0, xpos_q} == XMAX_W);
    assign moving[i]            = moving_q;
  end

endmodule
